// File: rtl/mem_stage.sv
// MEM pipeline stage: non-memory instructions pass straight through, while loads and
// stores run as a sequence of little-endian byte transfers over the req/gnt port.
module mem_stage #(
  parameter logic [6:0] LOAD_OP  = 7'b0000011,
  parameter logic [6:0] STORE_OP = 7'b0100011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        forward,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_val,
  input  logic [6:0]  ins_type,
  input  logic [2:0]  ins_details,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_val,
  output logic        mc_req,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [7:0]  mc_wdata,
  input  logic        mc_gnt,
  input  logic [7:0]  mc_rdata,
  output logic        stall_req,
  output logic        output_forward,
  output logic [4:0]  output_rd_addr,
  output logic [31:0] output_rd_val
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr;
  logic [31:0] val;
  logic [2:0]  details;
  logic [4:0]  rd_lat;
  logic        fwd_lat;
  logic        is_store;
  logic [1:0]  idx;
  logic [31:0] buffer;
  logic [1:0]  last_idx;
  logic        is_mem;
  logic [31:0] load_val;

  assign is_mem   = (ins_type == LOAD_OP) || (ins_type == STORE_OP);
  assign last_idx = details[1] ? 2'd3 : (details[0] ? 2'd1 : 2'd0);

  // Extension takes its sign from the highest byte actually read.
  always_comb begin
    load_val = buffer;
    case (details[1:0])
      2'b00:   load_val = {{24{~details[2] & buffer[7]}}, buffer[7:0]};
      2'b01:   load_val = {{16{~details[2] & buffer[15]}}, buffer[15:0]};
      default: load_val = buffer;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    mc_req         = 1'b0;
    mc_wr          = 1'b0;
    mc_addr        = 32'd0;
    mc_wdata       = 8'd0;
    stall_req      = 1'b0;
    output_forward = 1'b0;
    output_rd_addr = 5'd0;
    output_rd_val  = 32'd0;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          output_rd_addr = rd_addr;
          output_rd_val  = rd_val;
          if (!rdy_in || is_mem) begin
            stall_req = 1'b1;
          end else begin
            output_forward = forward;
          end
          if (rdy_in && is_mem) begin
            state_next = ACCESS;
          end
        end
        ACCESS: begin
          stall_req = 1'b1;
          mc_req    = rdy_in;
          mc_wr     = is_store;
          mc_addr   = addr + {30'd0, idx};
          mc_wdata  = val[{idx, 3'b000} +: 8];
          if (rdy_in && mc_gnt && (idx == last_idx)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          output_rd_addr = rd_lat;
          output_rd_val  = is_store ? 32'd0 : load_val;
          if (rdy_in) begin
            output_forward = fwd_lat & ~is_store;
            state_next     = IDLE;
          end else begin
            stall_req = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Access context is latched on entry; the buffer collects read bytes in place.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr     <= 32'd0;
      val      <= 32'd0;
      details  <= 3'd0;
      rd_lat   <= 5'd0;
      fwd_lat  <= 1'b0;
      is_store <= 1'b0;
      idx      <= 2'd0;
      buffer   <= 32'd0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (is_mem) begin
            addr     <= mem_addr;
            val      <= mem_val;
            details  <= ins_details;
            rd_lat   <= rd_addr;
            fwd_lat  <= forward;
            is_store <= (ins_type == STORE_OP);
            idx      <= 2'd0;
            buffer   <= 32'd0;
          end
        end
        ACCESS: begin
          if (mc_gnt) begin
            if (!is_store) begin
              buffer[{idx, 3'b000} +: 8] <= mc_rdata;
            end
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected bus bytes and writebacks are queued at issue
// and compared as the DUT requests transfers and presents results.
module tb_mem_stage;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [6:0] ALU_OP   = 7'b0010011;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } bus_t;

  typedef struct {
    logic        fwd;
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        forward;
  logic [4:0]  rd_addr;
  logic [31:0] rd_val;
  logic [6:0]  ins_type;
  logic [2:0]  ins_details;
  logic [31:0] mem_addr;
  logic [31:0] mem_val;
  logic        mc_req;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic        mc_gnt;
  logic [7:0]  mc_rdata;
  logic        stall_req;
  logic        output_forward;
  logic [4:0]  output_rd_addr;
  logic [31:0] output_rd_val;

  bus_t        bus_q[$];
  logic [7:0]  rdata_q[$];
  wb_t         wb_q[$];
  int          compared;
  int          mismatched;
  int          gnt_delay;
  int          wait_cnt;
  int          done_bytes;

  mem_stage dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .forward(forward), .rd_addr(rd_addr), .rd_val(rd_val),
    .ins_type(ins_type), .ins_details(ins_details),
    .mem_addr(mem_addr), .mem_val(mem_val),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_gnt(mc_gnt), .mc_rdata(mc_rdata),
    .stall_req(stall_req), .output_forward(output_forward),
    .output_rd_addr(output_rd_addr), .output_rd_val(output_rd_val)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Memory controller model: checks every request against the queued byte, grants after gnt_delay waits.
  initial begin
    mc_gnt   = 1'b0;
    mc_rdata = 8'd0;
    wait_cnt = 0;
    forever begin
      @(negedge clk_in);
      mc_gnt = 1'b0;
      if (mc_req) begin
        if (bus_q.size() == 0) begin
          checkOutput("unexpected_req", 32'(mc_req), 32'd0);
        end else begin
          checkOutput("bus_wr", 32'(mc_wr), 32'(bus_q[0].wr));
          checkOutput("bus_addr", mc_addr, bus_q[0].addr);
          if (bus_q[0].wr) checkOutput("bus_wdata", 32'(mc_wdata), 32'(bus_q[0].wdata));
          if (wait_cnt >= gnt_delay) begin
            mc_gnt = 1'b1;
            if (!bus_q[0].wr) mc_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'h00;
            void'(bus_q.pop_front());
            wait_cnt = 0;
            done_bytes++;
          end else begin
            wait_cnt++;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic driveNop();
    forward     = 1'b0;
    rd_addr     = 5'd0;
    rd_val      = 32'd0;
    ins_type    = 7'd0;
    ins_details = 3'd0;
    mem_addr    = 32'd0;
    mem_val     = 32'd0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mc_req"}, 32'(mc_req), 32'd0);
    checkOutput({tag, "_mc_wr"}, 32'(mc_wr), 32'd0);
    checkOutput({tag, "_mc_addr"}, mc_addr, 32'd0);
    checkOutput({tag, "_mc_wdata"}, 32'(mc_wdata), 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall_req), 32'd0);
    checkOutput({tag, "_fwd"}, 32'(output_forward), 32'd0);
    checkOutput({tag, "_rd"}, 32'(output_rd_addr), 32'd0);
    checkOutput({tag, "_val"}, output_rd_val, 32'd0);
  endtask

  // Non-memory instruction: result must appear in the same cycle with no stall.
  task automatic applyPass(input string tag, input logic fwd, input logic [4:0] rd, input logic [31:0] v);
    forward  = fwd;
    rd_addr  = rd;
    rd_val   = v;
    ins_type = ALU_OP;
    @(negedge clk_in);
    checkOutput({tag, "_fwd"}, 32'(output_forward), 32'(fwd));
    checkOutput({tag, "_rd"}, 32'(output_rd_addr), 32'(rd));
    checkOutput({tag, "_val"}, output_rd_val, v);
    checkOutput({tag, "_stall"}, 32'(stall_req), 32'd0);
    checkOutput({tag, "_mc_req"}, 32'(mc_req), 32'd0);
    @(posedge clk_in); #1;
    driveNop();
  endtask

  // mode 0: plain access, 1: rdy_in low 3 cycles after first byte, 2: reset after first byte.
  task automatic applyStimulus(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sval, input logic [4:0] rd,
                               input logic fwd, input logic [31:0] exp_val, input int exp_stall,
                               input int mode);
    int   nbytes;
    int   stall_cnt;
    logic got_done;
    logic gap_done;
    bus_t b;
    wb_t  w;
    wb_t  got;
    nbytes = f3[1] ? 4 : (f3[0] ? 2 : 1);
    for (int i = 0; i < nbytes; i++) begin
      b.wr    = (op == STORE_OP);
      b.addr  = addr + 32'(i);
      b.wdata = sval[8*i +: 8];
      bus_q.push_back(b);
    end
    w.fwd = fwd && (op == LOAD_OP);
    w.rd  = rd;
    w.val = (op == LOAD_OP) ? exp_val : 32'd0;
    wb_q.push_back(w);
    done_bytes  = 0;
    gap_done    = 1'b0;
    got_done    = 1'b0;
    forward     = fwd;
    rd_addr     = rd;
    rd_val      = 32'hDEAD_BEEF;
    ins_type    = op;
    ins_details = f3;
    mem_addr    = addr;
    mem_val     = sval;
    @(negedge clk_in);
    checkOutput({tag, "_issue_stall"}, 32'(stall_req), 32'd1);
    checkOutput({tag, "_issue_fwd"}, 32'(output_forward), 32'd0);
    stall_cnt = 1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk_in); #1;
      if (mode == 1 && done_bytes == 1 && !gap_done) begin
        rdy_in = 1'b0;
        repeat (3) begin
          @(negedge clk_in);
          checkOutput({tag, "_gap_req"}, 32'(mc_req), 32'd0);
          checkOutput({tag, "_gap_stall"}, 32'(stall_req), 32'd1);
          checkOutput({tag, "_gap_fwd"}, 32'(output_forward), 32'd0);
          stall_cnt++;
          @(posedge clk_in); #1;
        end
        rdy_in   = 1'b1;
        gap_done = 1'b1;
      end
      if (mode == 2 && done_bytes == 1) begin
        rst_in = 1'b1;
        @(negedge clk_in);
        checkAllZero({tag, "_abort"});
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        driveNop();
        bus_q.delete();
        rdata_q.delete();
        wb_q.delete();
        got_done = 1'b1;
        break;
      end
      @(negedge clk_in);
      if (!stall_req) begin
        got_done = 1'b1;
        break;
      end
      stall_cnt++;
    end
    checkOutput({tag, "_completed"}, 32'(got_done), 32'd1);
    if (mode != 2 && got_done) begin
      got = wb_q.pop_front();
      checkOutput({tag, "_wb_fwd"}, 32'(output_forward), 32'(got.fwd));
      checkOutput({tag, "_wb_rd"}, 32'(output_rd_addr), 32'(got.rd));
      checkOutput({tag, "_wb_val"}, output_rd_val, got.val);
      checkOutput({tag, "_done_req"}, 32'(mc_req), 32'd0);
      if (exp_stall >= 0) checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
      @(posedge clk_in); #1;
      driveNop();
      checkOutput({tag, "_bytes_left"}, 32'(bus_q.size()), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    gnt_delay  = 0;
    done_bytes = 0;
    rdy_in     = 1'b1;
    rst_in     = 1'b1;
    driveNop();
    ins_type    = LOAD_OP;
    ins_details = 3'b010;
    mem_addr    = 32'h0000_0040;
    forward     = 1'b1;
    rd_addr     = 5'd7;
    repeat (2) begin
      @(negedge clk_in);
      checkAllZero("reset");
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    driveNop();
    $display("[TB] reset released");

    applyPass("addi", 1'b1, 5'd5, 32'h0000_1234);

    gnt_delay = 0;
    rdata_q.push_back(8'h80);
    applyStimulus("lb", LOAD_OP, 3'b000, 32'h0000_0100, 32'd0, 5'd3, 1'b1, 32'hFFFF_FF80, 2, 0);
    rdata_q.push_back(8'h80);
    applyStimulus("lbu", LOAD_OP, 3'b100, 32'h0000_0100, 32'd0, 5'd4, 1'b1, 32'h0000_0080, 2, 0);

    gnt_delay = 2;
    applyStimulus("sw", STORE_OP, 3'b010, 32'h1FFF_FFFE, 32'hA1B2_C3D4, 5'd9, 1'b1, 32'd0, 13, 0);

    gnt_delay = 0;
    rdata_q.push_back(8'h34);
    rdata_q.push_back(8'h92);
    applyStimulus("lh", LOAD_OP, 3'b001, 32'h0000_0200, 32'd0, 5'd10, 1'b1, 32'hFFFF_9234, 6, 1);

    rdata_q.push_back(8'h11);
    rdata_q.push_back(8'h22);
    rdata_q.push_back(8'h33);
    rdata_q.push_back(8'h44);
    applyStimulus("lw_rst", LOAD_OP, 3'b010, 32'h0000_0300, 32'd0, 5'd12, 1'b1, 32'h4433_2211, -1, 2);
    applyPass("addi_after_rst", 1'b1, 5'd6, 32'h0000_0055);

    rdata_q.push_back(8'hEF);
    rdata_q.push_back(8'hBE);
    rdata_q.push_back(8'hAD);
    rdata_q.push_back(8'hDE);
    applyStimulus("lw", LOAD_OP, 3'b010, 32'hFFFF_FFFE, 32'd0, 5'd15, 1'b1, 32'hDEAD_BEEF, 5, 0);

    repeat (2) @(posedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
